// File: rtl/capture_dump_pkg.sv
// Shared types and constants for the capture RAM dump engine.
// The optional header byte is enabled with the CAPTURE_DUMP_HDR_EN macro.
package capture_dump_pkg;

  localparam int DEPTH_DEF = 512;
  localparam int AW_DEF    = 9;

  localparam logic [5:0] HDR_PREFIX = 6'b101010;

  typedef enum logic [2:0] {
    IDLE,
`ifdef CAPTURE_DUMP_HDR_EN
    HDR,
`endif
    RD,
    LATCH,
    SEND,
    WAIT_TX,
    FIN
  } state_t;

  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    return 3'b001 << ch;
  endfunction

endpackage

// File: rtl/capture_dump.sv
// Streams one channel of the capture RAM to a byte transmitter, oldest sample first.
// Defining CAPTURE_DUMP_HDR_EN prepends a {HDR_PREFIX, channel} header byte.
module capture_dump
  import capture_dump_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump,
  input  logic [1:0]    dump_ch,
  input  logic [AW-1:0] trace_end,
  input  logic [7:0]    rdata,
  input  logic          tx_done,
  output logic [AW-1:0] ram_addr,
  output logic [2:0]    ram_en,
  output logic [7:0]    tx_data,
  output logic          trmt,
  output logic          busy,
  output logic          dump_fin
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  state_t      state;
  logic [1:0]  ch;
  logic [AW:0] byte_cnt;

  // Strobes are registered and asserted on entry to the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= 2'd0;
      byte_cnt <= '0;
      ram_addr <= '0;
      ram_en   <= 3'b000;
      tx_data  <= 8'h00;
      trmt     <= 1'b0;
      busy     <= 1'b0;
      dump_fin <= 1'b0;
    end else begin
      ram_en   <= 3'b000;
      trmt     <= 1'b0;
      dump_fin <= 1'b0;
      case (state)
        IDLE: begin
          if (dump && dump_ch != 2'd3) begin
            ch       <= dump_ch;
            ram_addr <= trace_end + 1'b1;
            byte_cnt <= '0;
            busy     <= 1'b1;
`ifdef CAPTURE_DUMP_HDR_EN
            tx_data  <= {HDR_PREFIX, dump_ch};
            trmt     <= 1'b1;
            state    <= HDR;
`else
            ram_en   <= ch_onehot(dump_ch);
            state    <= RD;
`endif
          end
        end
`ifdef CAPTURE_DUMP_HDR_EN
        HDR: begin
          if (tx_done) begin
            ram_en <= ch_onehot(ch);
            state  <= RD;
          end
        end
`endif
        RD: state <= LATCH;
        LATCH: begin
          tx_data <= rdata;
          trmt    <= 1'b1;
          state   <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            byte_cnt <= byte_cnt + 1'b1;
            ram_addr <= ram_addr + 1'b1;
            if (byte_cnt == LAST_CNT) begin
              dump_fin <= 1'b1;
              state    <= FIN;
            end else begin
              ram_en <= ch_onehot(ch);
              state  <= RD;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_dump.sv
// Randomized self-checking bench for capture_dump with a RAM model, a
// transmitter that answers 5 clk after each trmt, and a stream-level reference.
module tb_capture_dump;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int TIMEOUT = 8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dump = 1'b0;
  logic [1:0]    dump_ch = 2'd0;
  logic [AW-1:0] trace_end = '0;
  logic [7:0]    rdata = 8'h00;
  logic          tx_done = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [2:0]    ram_en;
  logic [7:0]    tx_data;
  logic          trmt;
  logic          busy;
  logic          dump_fin;

  capture_dump #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .dump(dump), .dump_ch(dump_ch),
    .trace_end(trace_end), .rdata(rdata), .tx_done(tx_done),
    .ram_addr(ram_addr), .ram_en(ram_en), .tx_data(tx_data),
    .trmt(trmt), .busy(busy), .dump_fin(dump_fin)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int start_cyc = 0;

  logic [7:0] mem [3][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read capture RAM: data appears one clk after ram_en.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (ram_en[k]) rdata <= mem[k][ram_addr];
  end

  // Transmitter: reports completion 5 clk after each strobe.
  int tx_cnt = 0;
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) tx_cnt = 0;
    else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (trmt) tx_cnt = 5;
    end
  end

  logic [7:0]    got_bytes[$];
  logic [AW-1:0] got_addr[$];
  logic [2:0]    got_en[$];
  int            n_fin = 0;
  int            first_trmt_cyc = -1;

  always @(negedge clk) begin
    if (trmt) begin
      if (got_bytes.size() == 0) first_trmt_cyc = cyc;
      got_bytes.push_back(tx_data);
    end
    if (ram_en != 3'b000) begin
      got_addr.push_back(ram_addr);
      got_en.push_back(ram_en);
    end
    if (dump_fin) n_fin++;
  end

`ifdef CAPTURE_DUMP_HDR_EN
  localparam int HDR_BYTES = 1;
  localparam int LATENCY   = 1;
`else
  localparam int HDR_BYTES = 0;
  localparam int LATENCY   = 3;
`endif

  task automatic clear_mon();
    got_bytes.delete();
    got_addr.delete();
    got_en.delete();
    n_fin = 0;
    first_trmt_cyc = -1;
  endtask

  task automatic start_dump(input logic [AW-1:0] te, input logic [1:0] ch);
    @(negedge clk);
    trace_end = te;
    dump_ch   = ch;
    dump      = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    dump      = 1'b0;
    trace_end = AW'($urandom);
  endtask

  task automatic wait_fin(output bit timed_out);
    int n;
    n = 0;
    while (n_fin == 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n_fin == 0);
    repeat (3) @(negedge clk);
  endtask

  // Reference: header (optional) then mem[ch][(te+1+i) mod DEPTH] for i in 0..DEPTH-1.
  task automatic score(input logic [AW-1:0] te, input logic [1:0] ch,
                       output int byte_err, output int addr_err, output int en_err);
    logic [7:0]    exp_b[$];
    logic [AW-1:0] a;
    int            m;
    exp_b = {};
    if (HDR_BYTES == 1) exp_b.push_back({6'b101010, ch});
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'((int'(te) + 1 + i) % DEPTH);
      exp_b.push_back(mem[ch][a]);
    end
    m = (got_bytes.size() < exp_b.size()) ? got_bytes.size() : exp_b.size();
    byte_err = (got_bytes.size() > exp_b.size()) ? got_bytes.size() - exp_b.size()
                                                 : exp_b.size() - got_bytes.size();
    for (int i = 0; i < m; i++)
      if (got_bytes[i] !== exp_b[i]) byte_err++;
    m = (got_addr.size() < DEPTH) ? got_addr.size() : DEPTH;
    addr_err = (got_addr.size() > DEPTH) ? got_addr.size() - DEPTH : DEPTH - got_addr.size();
    for (int i = 0; i < m; i++)
      if (got_addr[i] !== AW'((int'(te) + 1 + i) % DEPTH)) addr_err++;
    en_err = 0;
    for (int i = 0; i < got_en.size(); i++)
      if (got_en[i] !== (3'b001 << ch)) en_err++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({ram_addr, ram_en, tx_data} !== '0) $display("[TB] FAIL reset_data: addr=%h en=%b tx=%h, want 0", ram_addr, ram_en, tx_data); else passed++;
    total++; if (trmt !== 1'b0) $display("[TB] FAIL reset_trmt: got %b want 0", trmt); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (dump_fin !== 1'b0) $display("[TB] FAIL reset_fin: got %b want 0", dump_fin); else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_dump(input logic [AW-1:0] te, input logic [1:0] ch, input string name);
    bit to;
    int be, ae, ee;
    clear_mon();
    start_dump(te, ch);
    total++; if (busy !== 1'b1) $display("[TB] FAIL %s_busy: got %b want 1", name, busy); else passed++;
    wait_fin(to);
    total++; if (to) $display("[TB] FAIL %s_timeout: no dump_fin within %0d clk", name, TIMEOUT); else passed++;
    score(te, ch, be, ae, ee);
    total++; if (first_trmt_cyc - start_cyc != LATENCY) $display("[TB] FAIL %s_latency: got %0d want %0d", name, first_trmt_cyc - start_cyc, LATENCY); else passed++;
    total++; if (got_bytes.size() != DEPTH + HDR_BYTES) $display("[TB] FAIL %s_trmt_count: got %0d want %0d", name, got_bytes.size(), DEPTH + HDR_BYTES); else passed++;
    total++; if (be != 0) $display("[TB] FAIL %s_bytes: %0d wrong bytes, want 0", name, be); else passed++;
    total++; if (ae != 0) $display("[TB] FAIL %s_addr_seq: %0d wrong addresses, want 0", name, ae); else passed++;
    total++; if (ee != 0) $display("[TB] FAIL %s_ram_en: %0d bad enables, want 0", name, ee); else passed++;
    if (got_addr.size() > 0) begin
      total++; if (got_addr[0] !== te + 1'b1) $display("[TB] FAIL %s_first_addr: got %h want %h", name, got_addr[0], te + 1'b1); else passed++;
      total++; if (got_addr[got_addr.size()-1] !== te) $display("[TB] FAIL %s_last_addr: got %h want %h", name, got_addr[got_addr.size()-1], te); else passed++;
    end else begin
      total++; $display("[TB] FAIL %s_addr_seen: got 0 reads want %0d", name, DEPTH);
    end
    total++; if (n_fin != 1) $display("[TB] FAIL %s_fin_count: got %0d want 1", name, n_fin); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL %s_busy_end: got %b want 0", name, busy); else passed++;
  endtask

  task automatic test_ignore_busy();
    logic [AW-1:0] te;
    int n, be, ae, ee;
    bit hit;
    te = AW'($urandom);
    clear_mon();
    start_dump(te, 2'd1);
    n = 0;
    while (got_bytes.size() < 20 && n < TIMEOUT) begin @(negedge clk); n++; end
    dump = 1'b1; dump_ch = 2'd2; trace_end = te + 9'd77;
    @(negedge clk);
    dump = 1'b0;
    hit = 1'b0;
    n = 0;
    while (!hit && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (dump_fin) begin
        hit = 1'b1;
        dump = 1'b1; dump_ch = 2'd2; trace_end = te + 9'd5;
        @(negedge clk);
        dump = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    total++; if (!hit) $display("[TB] FAIL ign_timeout: no dump_fin within %0d clk", TIMEOUT); else passed++;
    score(te, 2'd1, be, ae, ee);
    total++; if (ee != 0) $display("[TB] FAIL ign_channel: %0d enables not 010, want 0", ee); else passed++;
    total++; if (ae != 0) $display("[TB] FAIL ign_addr_seq: %0d wrong addresses, want 0", ae); else passed++;
    total++; if (be != 0) $display("[TB] FAIL ign_bytes: %0d wrong bytes, want 0", be); else passed++;
    total++; if (n_fin != 1) $display("[TB] FAIL ign_fin_count: got %0d want 1", n_fin); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL ign_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reserved_ch();
    bit busy_seen;
    clear_mon();
    start_dump(AW'($urandom), 2'd3);
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    total++; if (busy_seen) $display("[TB] FAIL rsv_busy: got 1 want 0"); else passed++;
    total++; if (got_en.size() != 0) $display("[TB] FAIL rsv_ram_en: got %0d reads want 0", got_en.size()); else passed++;
    total++; if (got_bytes.size() != 0) $display("[TB] FAIL rsv_trmt: got %0d strobes want 0", got_bytes.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    start_dump(AW'($urandom), 2'd0);
    n = 0;
    while (got_bytes.size() < 100 && n < TIMEOUT) begin @(negedge clk); n++; end
    total++; if (got_bytes.size() < 100) $display("[TB] FAIL rstmid_progress: got %0d bytes want 100", got_bytes.size()); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({ram_addr, ram_en, tx_data, trmt, busy, dump_fin} !== '0)
      $display("[TB] FAIL rstmid_outputs: addr=%h en=%b tx=%h trmt=%b busy=%b fin=%b, want all 0", ram_addr, ram_en, tx_data, trmt, busy, dump_fin);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (n_fin != 0) $display("[TB] FAIL rstmid_fin: got %0d want 0", n_fin); else passed++;
    test_full_dump(AW'($urandom), 2'($urandom_range(0, 2)), "after_reset");
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++)
        mem[k][i] = 8'($urandom);
    test_reset();
    test_full_dump(9'h1FF, 2'd1, "full_1ff");
    test_full_dump(9'h0A5, 2'd2, "wrap_0a5");
    test_full_dump(AW'($urandom), 2'($urandom_range(0, 2)), "random");
    test_ignore_busy();
    test_reserved_ch();
    test_reset_mid();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
